el2_pmp_chan_arb: RTL and testbench
===================================

Name: el2_pmp_chan_arb

Overview:
Shares a single el2_pmp check channel among NUM_REQ requesters, for example the debug SB, DMA and trace-fetch ports, which would otherwise each need a dedicated PMP channel. It applies round-robin arbitration, registers the winning address and type onto the PMP channel, samples pmp_chan_err, and returns a per-requester response through a valid/ready handshake. Only one check is outstanding at a time. A PMP CSR update during a check forces a re-check, so no response is ever computed against a stale configuration.

Parameters:
NUM_REQ, 3, number of requesters sharing the channel (2..8)
IDX_W, $clog2(NUM_REQ), width of the round-robin pointer and grant index

Ports:
clk  input  1  top-level clock
rst_l  input  1  reset; asynchronous, active-low
req_valid  input  NUM_REQ  per-requester check request
req_addr  input  NUM_REQ x 32  per-requester byte address
req_type  input  NUM_REQ x el2_pmp_type_pkt_t  access type (READ/WRITE/EXEC)
req_ready  output  NUM_REQ  one-hot grant; request accepted when valid & ready
rsp_valid  output  NUM_REQ  one-hot response valid to the granted requester
rsp_err  output  1  1 = access fault; meaningful only while any rsp_valid is high
rsp_ready  input  NUM_REQ  per-requester response acceptance
pmp_cfg_upd  input  1  pulse: pmpcfg/pmpaddr CSR written this cycle
pmp_chan_addr  output  32  address driven to the el2_pmp channel
pmp_chan_type  output  el2_pmp_type_pkt_t  type driven to the el2_pmp channel
pmp_chan_err  input  1  combinational PMP fault result for the driven addr/type
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync release) sets:
  - state=IDLE, rr_ptr=0
  - req_ready=0, rsp_valid=0, rsp_err=0
  - pmp_chan_addr=0, pmp_chan_type=READ, busy=0
- State machine has three states: IDLE, CHECK, RESP.
- IDLE:
  - req_ready is combinational and one-hot: the first valid requester at or after rr_ptr (modulo NUM_REQ). It is all-zero if no request is valid or pmp_cfg_upd=1.
  - On acceptance:
    - register addr/type into pmp_chan_addr/pmp_chan_type
    - register grant index gnt_idx
    - set rr_ptr = gnt_idx+1 (wraps NUM_REQ-1 -> 0)
    - go to CHECK
- CHECK (lasts at least 1 cycle):
  - pmp_chan_addr/type are stable from the register.
  - If pmp_cfg_upd=1: stay in CHECK and discard the result. Repeated pulses extend the state indefinitely.
  - Otherwise: rsp_err <= pmp_chan_err, rsp_valid[gnt_idx] <= 1, go to RESP.
- RESP:
  - rsp_valid[gnt_idx] and rsp_err are held stable until rsp_ready[gnt_idx]=1.
  - On that handshake: rsp_valid cleared, go to IDLE.
  - pmp_cfg_upd in RESP is ignored; the response is already committed.
  - rsp_ready bits of non-granted requesters are ignored.
- Latency and throughput:
  - Acceptance at cycle N gives rsp_valid at cycle N+2 (no cfg update).
  - Maximum throughput is one check per 3 cycles when rsp_ready is tied high.
- req_ready is never asserted outside IDLE; requesters must hold req_valid/addr/type until accepted.
- A requester dropping req_valid before acceptance is legal; the arbiter simply skips it.
- pmp_chan_addr/type keep their last granted value in IDLE. They do not toggle, to save power.
- The el2_pmp output is combinational; this block adds the only register stage (rsp_err).
- Fairness: with all NUM_REQ requesting continuously, grants rotate 0,1,...,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 grants.
- Reset asserted mid-CHECK or mid-RESP: the response is dropped with no rsp_valid, and the state machine returns to IDLE.
- Assertions:
  - req_ready and rsp_valid are each $onehot0.
  - rsp_valid never asserts while state != RESP.

Test Plan:
- Single request: req_valid=3'b010, addr=0x2000_0000, type=WRITE, pmp_chan_err=1.
  - Expect req_ready=3'b010 in cycle 0.
  - Expect pmp_chan_addr=0x2000_0000 in cycle 1.
  - Expect rsp_valid=3'b010 and rsp_err=1 in cycle 2.
- Round robin: all three requesters valid continuously, rsp_ready=3'b111.
  - Expect grant order 0,1,2,0,1,2.
  - Expect grants exactly 3 cycles apart.
- Backpressure: rsp_ready[0]=0 for 5 cycles after rsp_valid[0] rises.
  - Expect rsp_valid/rsp_err held stable and busy=1.
  - Expect req_ready=0 despite req_valid[1]=1.
  - After release, requester 1 is granted on the cycle following the handshake.
- Config update during check: pmp_cfg_upd pulsed in the CHECK cycle, and pmp_chan_err changes 1->0 the next cycle.
  - Expect CHECK extended by 1 cycle.
  - Expect rsp_err=0 at cycle N+3.
- Update in IDLE: pmp_cfg_upd=1 with req_valid=3'b001.
  - Expect req_ready=0 that cycle and grant on the next cycle.
- Reset mid-RESP: assert rst_l=0 while rsp_valid=3'b100.
  - Expect all outputs to 0 immediately (asynchronously).
  - After release, rr_ptr=0 and requester 0 wins when all requesters are valid.

Source files
------------

// File: rtl/el2_pmp_chan_arb.sv
// Round-robin arbiter that time-shares one el2_pmp check channel among NUM_REQ
// requesters, with one check outstanding and a re-check on PMP CSR updates.

package el2_pmp_chan_arb_pkg;

    typedef enum logic [1:0] {
        READ  = 2'b00,
        WRITE = 2'b01,
        EXEC  = 2'b10
    } el2_pmp_type_pkt_t;

endpackage : el2_pmp_chan_arb_pkg

module el2_pmp_chan_arb
    import el2_pmp_chan_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_l,

    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0][31:0]      req_addr,
    input  el2_pmp_type_pkt_t [NUM_REQ-1:0] req_type,
    output logic [NUM_REQ-1:0]            req_ready,

    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic                          rsp_err,
    input  logic [NUM_REQ-1:0]            rsp_ready,

    input  logic                          pmp_cfg_upd,
    output logic [31:0]                   pmp_chan_addr,
    output el2_pmp_type_pkt_t             pmp_chan_type,
    input  logic                          pmp_chan_err,

    output logic                          busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CHECK = 2'b01,
        RESP  = 2'b10
    } state_e;

    state_e               state;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     gnt_idx;

    logic                 arb_hit;
    logic [IDX_W-1:0]     arb_idx;
    logic [NUM_REQ-1:0]   arb_onehot;
    logic [IDX_W-1:0]     rr_ptr_nxt;
    logic [NUM_REQ-1:0]   gnt_onehot;
    logic                 accept;

    // Search starts at rr_ptr and wraps, so the most recent winner is tried last.
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        int cand;
        arb_hit = 1'b0;
        arb_idx = '0;
        cand    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(rr_ptr) + i) % NUM_REQ;
            if (!arb_hit && req_valid[IDX_W'(cand)]) begin
                arb_hit = 1'b1;
                arb_idx = IDX_W'(cand);
            end
        end
    end

    assign arb_onehot = arb_hit ? (NUM_REQ'(1) << arb_idx) : '0;
    assign gnt_onehot = NUM_REQ'(1) << gnt_idx;

    assign rr_ptr_nxt = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);

    // Gating with rst_l keeps the combinational grant low while reset is held,
    // since the IDLE state alone would otherwise let it follow req_valid.
    // A CSR write in the acceptance cycle would race the registered check, so
    // acceptance is deferred one cycle.
    assign req_ready = (state == IDLE && !pmp_cfg_upd && rst_l) ? arb_onehot : '0;
    assign accept    = |req_ready;

    assign busy = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            gnt_idx       <= '0;
            rsp_valid     <= '0;
            rsp_err       <= 1'b0;
            pmp_chan_addr <= '0;
            pmp_chan_type <= READ;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        pmp_chan_addr <= req_addr[arb_idx];
                        pmp_chan_type <= req_type[arb_idx];
                        gnt_idx       <= arb_idx;
                        rr_ptr        <= rr_ptr_nxt;
                        state         <= CHECK;
                    end
                end

                // A CSR update makes this cycle's result untrustworthy; hold the
                // channel and sample again once the configuration is quiet.
                CHECK: begin
                    if (!pmp_cfg_upd) begin
                        rsp_err   <= pmp_chan_err;
                        rsp_valid <= gnt_onehot;
                        state     <= RESP;
                    end
                end

                RESP: begin
                    if (rsp_ready[gnt_idx]) begin
                        rsp_valid <= '0;
                        rsp_err   <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    rsp_valid <= '0;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    a_req_ready_onehot: assert property (
        @(posedge clk) disable iff (!rst_l) $onehot0(req_ready));

    a_rsp_valid_onehot: assert property (
        @(posedge clk) disable iff (!rst_l) $onehot0(rsp_valid));

    a_rsp_valid_in_resp: assert property (
        @(posedge clk) disable iff (!rst_l) (state != RESP) |-> (rsp_valid == '0));
`endif

endmodule : el2_pmp_chan_arb

// File: tb/tb_el2_pmp_chan_arb.sv
// Directed bench for el2_pmp_chan_arb: a cycle table plus a hand-written
// reset-during-response sequence.

module tb_el2_pmp_chan_arb;
    import el2_pmp_chan_arb_pkg::*;

    localparam int NUM_REQ = 3;

    localparam logic [31:0] A0 = 32'h1000_0000;
    localparam logic [31:0] A1 = 32'h2000_0000;
    localparam logic [31:0] A2 = 32'h3000_0000;

    logic                            clk = 1'b0;
    logic                            rst_l = 1'b0;
    logic [NUM_REQ-1:0]              req_valid;
    logic [NUM_REQ-1:0][31:0]        req_addr;
    el2_pmp_type_pkt_t [NUM_REQ-1:0] req_type;
    logic [NUM_REQ-1:0]              req_ready;
    logic [NUM_REQ-1:0]              rsp_valid;
    logic                            rsp_err;
    logic [NUM_REQ-1:0]              rsp_ready;
    logic                            pmp_cfg_upd;
    logic [31:0]                     pmp_chan_addr;
    el2_pmp_type_pkt_t               pmp_chan_type;
    logic                            pmp_chan_err;
    logic                            busy;

    always #5 clk = ~clk;

    el2_pmp_chan_arb #(.NUM_REQ(NUM_REQ)) dut (
        .clk           (clk),
        .rst_l         (rst_l),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_type      (req_type),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_err       (rsp_err),
        .rsp_ready     (rsp_ready),
        .pmp_cfg_upd   (pmp_cfg_upd),
        .pmp_chan_addr (pmp_chan_addr),
        .pmp_chan_type (pmp_chan_type),
        .pmp_chan_err  (pmp_chan_err),
        .busy          (busy)
    );

    typedef struct {
        logic [2:0]  rv;
        logic [2:0]  rr;
        logic        upd;
        logic        perr;
        logic [2:0]  rdy;
        logic [2:0]  rspv;
        logic        rerr;
        logic        bsy;
        logic [31:0] addr;
    } vec_t;

    vec_t vecs[$];
    vec_t v;
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [2:0] rv, input logic [2:0] rr, input logic upd,
                       input logic perr, input logic [2:0] rdy, input logic [2:0] rspv,
                       input logic rerr, input logic bsy, input logic [31:0] addr);
        vecs.push_back('{rv, rr, upd, perr, rdy, rspv, rerr, bsy, addr});
    endtask

    // Requester i always presents address (i+1)<<28; its type follows from that.
    function automatic el2_pmp_type_pkt_t type_for(input logic [31:0] a);
        case (a)
            A1:      return WRITE;
            A2:      return EXEC;
            default: return READ;
        endcase
    endfunction

    initial begin
        req_valid    = '0;
        rsp_ready    = '0;
        pmp_cfg_upd  = 1'b0;
        pmp_chan_err = 1'b0;
        req_addr[0]  = A0;
        req_addr[1]  = A1;
        req_addr[2]  = A2;
        req_type[0]  = READ;
        req_type[1]  = WRITE;
        req_type[2]  = EXEC;

        //   rv      rr      upd   perr  rdy     rspv    rerr  bsy   addr
        // Round robin from reset, all requesting: grants 0,1,2,0,1,2 every 3 cycles.
        add(3'b111, 3'b111, 1'b0, 1'b0, 3'b001, 3'b000, 1'b0, 1'b0, 32'h0);
        add(3'b111, 3'b111, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1, A0);
        add(3'b111, 3'b111, 1'b0, 1'b0, 3'b000, 3'b001, 1'b0, 1'b1, A0);
        add(3'b111, 3'b111, 1'b0, 1'b0, 3'b010, 3'b000, 1'b0, 1'b0, A0);
        add(3'b111, 3'b111, 1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 1'b1, A1);
        add(3'b111, 3'b111, 1'b0, 1'b0, 3'b000, 3'b010, 1'b1, 1'b1, A1);
        add(3'b111, 3'b111, 1'b0, 1'b0, 3'b100, 3'b000, 1'b0, 1'b0, A1);
        add(3'b111, 3'b111, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1, A2);
        add(3'b111, 3'b111, 1'b0, 1'b0, 3'b000, 3'b100, 1'b0, 1'b1, A2);
        add(3'b111, 3'b111, 1'b0, 1'b0, 3'b001, 3'b000, 1'b0, 1'b0, A2);
        add(3'b111, 3'b111, 1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 1'b1, A0);
        add(3'b111, 3'b111, 1'b0, 1'b0, 3'b000, 3'b001, 1'b1, 1'b1, A0);
        add(3'b111, 3'b111, 1'b0, 1'b0, 3'b010, 3'b000, 1'b0, 1'b0, A0);
        add(3'b111, 3'b111, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1, A1);
        add(3'b111, 3'b111, 1'b0, 1'b0, 3'b000, 3'b010, 1'b0, 1'b1, A1);
        add(3'b111, 3'b111, 1'b0, 1'b0, 3'b100, 3'b000, 1'b0, 1'b0, A1);
        add(3'b111, 3'b111, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1, A2);
        add(3'b111, 3'b111, 1'b0, 1'b0, 3'b000, 3'b100, 1'b0, 1'b1, A2);
        // Single WRITE request from requester 1 with a fault.
        add(3'b010, 3'b000, 1'b0, 1'b1, 3'b010, 3'b000, 1'b0, 1'b0, A2);
        add(3'b000, 3'b000, 1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 1'b1, A1);
        add(3'b000, 3'b000, 1'b0, 1'b1, 3'b000, 3'b010, 1'b1, 1'b1, A1);
        add(3'b000, 3'b010, 1'b0, 1'b0, 3'b000, 3'b010, 1'b1, 1'b1, A1);
        add(3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, A1);
        // Backpressure on requester 0 for 5 cycles; requester 1 waits; other rsp_ready bits ignored.
        add(3'b001, 3'b000, 1'b0, 1'b1, 3'b001, 3'b000, 1'b0, 1'b0, A1);
        add(3'b010, 3'b000, 1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 1'b1, A0);
        add(3'b010, 3'b110, 1'b0, 1'b0, 3'b000, 3'b001, 1'b1, 1'b1, A0);
        add(3'b010, 3'b110, 1'b0, 1'b0, 3'b000, 3'b001, 1'b1, 1'b1, A0);
        add(3'b010, 3'b110, 1'b0, 1'b0, 3'b000, 3'b001, 1'b1, 1'b1, A0);
        add(3'b010, 3'b110, 1'b0, 1'b0, 3'b000, 3'b001, 1'b1, 1'b1, A0);
        add(3'b010, 3'b110, 1'b0, 1'b0, 3'b000, 3'b001, 1'b1, 1'b1, A0);
        add(3'b010, 3'b111, 1'b0, 1'b0, 3'b000, 3'b001, 1'b1, 1'b1, A0);
        add(3'b010, 3'b111, 1'b0, 1'b0, 3'b010, 3'b000, 1'b0, 1'b0, A0);
        add(3'b000, 3'b111, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1, A1);
        add(3'b000, 3'b111, 1'b0, 1'b0, 3'b000, 3'b010, 1'b0, 1'b1, A1);
        add(3'b000, 3'b111, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, A1);
        // CSR update in the CHECK cycle: one extra CHECK cycle, fresh result used.
        add(3'b100, 3'b111, 1'b0, 1'b1, 3'b100, 3'b000, 1'b0, 1'b0, A1);
        add(3'b000, 3'b111, 1'b1, 1'b1, 3'b000, 3'b000, 1'b0, 1'b1, A2);
        add(3'b000, 3'b111, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1, A2);
        add(3'b000, 3'b111, 1'b0, 1'b0, 3'b000, 3'b100, 1'b0, 1'b1, A2);
        add(3'b000, 3'b111, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, A2);
        // CSR update in IDLE defers the grant; an update in RESP is ignored.
        add(3'b001, 3'b111, 1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, A2);
        add(3'b001, 3'b111, 1'b0, 1'b0, 3'b001, 3'b000, 1'b0, 1'b0, A2);
        add(3'b000, 3'b111, 1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 1'b1, A0);
        add(3'b000, 3'b111, 1'b1, 1'b0, 3'b000, 3'b001, 1'b1, 1'b1, A0);
        add(3'b000, 3'b111, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, A0);

        // Reset state, with requests present to show req_ready stays low.
        req_valid = 3'b111;
        #2;
        check("reset req_ready", 32'(req_ready), 32'h0);
        check("reset rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset rsp_err", 32'(rsp_err), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        check("reset chan_addr", pmp_chan_addr, 32'h0);
        check("reset chan_type", 32'(pmp_chan_type), 32'(READ));
        req_valid = '0;
        @(posedge clk);
        #1;
        rst_l = 1'b1;

        for (int k = 0; k < vecs.size(); k++) begin
            v            = vecs[k];
            req_valid    = v.rv;
            rsp_ready    = v.rr;
            pmp_cfg_upd  = v.upd;
            pmp_chan_err = v.perr;
            @(negedge clk);
            check($sformatf("vec%0d req_ready", k), 32'(req_ready), 32'(v.rdy));
            check($sformatf("vec%0d rsp_valid", k), 32'(rsp_valid), 32'(v.rspv));
            check($sformatf("vec%0d rsp_err", k), 32'(rsp_err), 32'(v.rerr));
            check($sformatf("vec%0d busy", k), 32'(busy), 32'(v.bsy));
            check($sformatf("vec%0d chan_addr", k), pmp_chan_addr, v.addr);
            check($sformatf("vec%0d chan_type", k), 32'(pmp_chan_type), 32'(type_for(v.addr)));
            @(posedge clk);
            #1;
        end

        // Reset while requester 2's response is pending; rr_ptr is 1 here.
        req_valid    = 3'b100;
        rsp_ready    = 3'b000;
        pmp_cfg_upd  = 1'b0;
        pmp_chan_err = 1'b1;
        @(negedge clk);
        check("rst_seq grant2", 32'(req_ready), 32'b100);
        @(posedge clk);
        #1;
        req_valid = 3'b000;
        @(posedge clk);
        #1;
        check("rst_seq rsp_valid", 32'(rsp_valid), 32'b100);
        check("rst_seq rsp_err", 32'(rsp_err), 32'h1);
        req_valid = 3'b111;
        #2;
        rst_l = 1'b0;
        #1;
        check("rst_async req_ready", 32'(req_ready), 32'h0);
        check("rst_async rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_async rsp_err", 32'(rsp_err), 32'h0);
        check("rst_async busy", 32'(busy), 32'h0);
        check("rst_async chan_addr", pmp_chan_addr, 32'h0);
        check("rst_async chan_type", 32'(pmp_chan_type), 32'(READ));
        @(posedge clk);
        #1;
        check("rst_held rsp_valid", 32'(rsp_valid), 32'h0);
        rst_l = 1'b1;
        #1;
        check("rst_rel grant0", 32'(req_ready), 32'b001);
        @(posedge clk);
        #1;
        check("rst_rel chan_addr", pmp_chan_addr, A0);
        check("rst_rel busy", 32'(busy), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_el2_pmp_chan_arb
